// File: rtl/stage_if.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Keeps one fetch in flight on a request/ready memory port, presents
// registered pc/inst/valid to decode, and honours decode's stall and
// same-cycle branch/jump redirect.
//
// state | meaning
// IDLE  | just out of reset, first request not yet issued
// WAIT  | request outstanding at mem_addr, waiting for mem_ready
// HOLD  | fetched word parked in hold buffer while decode stalls
module stage_if #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br,
    input  logic [31:0] br_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] mem_addr_n;
    logic        mem_req_n;
    logic        discard, discard_n;
    logic [31:0] hold_pc, hold_pc_n;
    logic [31:0] hold_inst, hold_inst_n;
    logic [31:0] if_pc_n, if_inst_n;
    logic        if_valid_n;

    // Redirect targets are forced word-aligned; the low two bits are dropped.
    logic [31:0] target;
    logic [31:0] addr_inc;
    logic [31:0] hold_inc;

    assign target   = br_addr & ~32'h0000_0003;
    assign addr_inc = mem_addr + 32'd4;
    assign hold_inc = hold_pc + 32'd4;

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            mem_addr    <= 32'h0000_0000;
            mem_req     <= 1'b0;
            discard     <= 1'b0;
            hold_pc     <= 32'h0000_0000;
            hold_inst   <= BUBBLE_INST;
            if_id_pc    <= 32'h0000_0000;
            if_id_inst  <= BUBBLE_INST;
            if_id_valid <= 1'b0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            mem_addr    <= mem_addr_n;
            mem_req     <= mem_req_n;
            discard     <= discard_n;
            hold_pc     <= hold_pc_n;
            hold_inst   <= hold_inst_n;
            if_id_pc    <= if_pc_n;
            if_id_inst  <= if_inst_n;
            if_id_valid <= if_valid_n;
        end
    end

    // Next-state and next-register values; everything holds by default.
    always_comb begin
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        mem_addr_n  = mem_addr;
        mem_req_n   = mem_req;
        discard_n   = discard;
        hold_pc_n   = hold_pc;
        hold_inst_n = hold_inst;
        if_pc_n     = if_id_pc;
        if_inst_n   = if_id_inst;
        if_valid_n  = if_id_valid;

        case (state)
            IDLE: begin
                mem_req_n  = 1'b1;
                mem_addr_n = fetch_pc;
                state_n    = WAIT;
            end

            WAIT: begin
                if (stall) begin
                    // IF/ID frozen; a returning word is either stale or parked.
                    if (mem_ready) begin
                        if (discard) begin
                            discard_n  = 1'b0;
                            mem_addr_n = fetch_pc;
                        end else begin
                            hold_pc_n   = mem_addr;
                            hold_inst_n = mem_rdata;
                            mem_req_n   = 1'b0;
                            state_n     = HOLD;
                        end
                    end
                end else begin
                    if_inst_n  = BUBBLE_INST;
                    if_valid_n = 1'b0;
                    if (br) begin
                        fetch_pc_n = target;
                        if (mem_ready) begin
                            mem_addr_n = target;
                            discard_n  = 1'b0;
                        end else begin
                            // Request in flight must complete before the
                            // address may change; its data will be dropped.
                            discard_n = 1'b1;
                        end
                    end else if (mem_ready) begin
                        if (discard) begin
                            discard_n  = 1'b0;
                            mem_addr_n = fetch_pc;
                        end else begin
                            if_pc_n    = mem_addr;
                            if_inst_n  = mem_rdata;
                            if_valid_n = 1'b1;
                            fetch_pc_n = addr_inc;
                            mem_addr_n = addr_inc;
                        end
                    end
                end
            end

            HOLD: begin
                if (!stall) begin
                    mem_req_n = 1'b1;
                    state_n   = WAIT;
                    if (br) begin
                        if_inst_n  = BUBBLE_INST;
                        if_valid_n = 1'b0;
                        fetch_pc_n = target;
                        mem_addr_n = target;
                    end else begin
                        if_pc_n    = hold_pc;
                        if_inst_n  = hold_inst;
                        if_valid_n = 1'b1;
                        fetch_pc_n = hold_inc;
                        mem_addr_n = hold_inc;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: a latency-programmable instruction memory answers
// requests; expected request addresses and expected IF/ID instructions
// are queued by the stimulus and popped by independent monitors.
module tb_stage_if;

    localparam logic [31:0] KEY    = 32'hA5A5_0000;
    localparam logic [31:0] BUBBLE = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] br_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;

    int n_cmp = 0;
    int n_bad = 0;
    int lat   = 0;
    int cnt   = 0;
    logic s_stall = 1'b0;

    logic [31:0] exp_req[$];
    logic [31:0] exp_if[$];

    stage_if dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br          (br),
        .br_addr     (br_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .if_id_pc    (if_id_pc),
        .if_id_inst  (if_id_inst),
        .if_id_valid (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pc(input logic [31:0] pc);
        int n = 0;
        while (!(if_id_valid === 1'b1 && if_id_pc === pc) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_pc timeout: got pc %h expected %h", if_id_pc, pc);
        end
    endtask

    // Memory model: answers each request after lat idle negedges.
    always @(negedge clk) begin
        if (rst) begin
            mem_ready = 1'b0;
            cnt = lat;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            cnt = lat;
        end else if (mem_req) begin
            if (cnt == 0) begin
                mem_ready = 1'b1;
                mem_rdata = mem_addr ^ KEY;
                if (exp_req.size() == 0)
                    check("unexpected_req", mem_addr, 32'hDEAD_BEEF);
                else
                    check("req_addr", mem_addr, exp_req.pop_front());
            end else begin
                cnt = cnt - 1;
            end
        end else begin
            cnt = lat;
        end
    end

    // IF/ID monitor: a valid word is new if decode was not stalling at the edge.
    always @(posedge clk) s_stall = stall;

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && !s_stall && if_id_valid === 1'b1) begin
            if (exp_if.size() == 0) begin
                check("unexpected_ifid", if_id_pc, 32'hDEAD_BEEF);
            end else begin
                e = exp_if.pop_front();
                check("ifid_pc", if_id_pc, e);
                check("ifid_inst", if_id_inst, e ^ KEY);
            end
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; br = 1'b0; br_addr = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        #1;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_ifid_pc", if_id_pc, 32'd0);
        check("rst_ifid_inst", if_id_inst, BUBBLE);
        check("rst_ifid_valid", {31'b0, if_id_valid}, 32'd0);

        foreach (exp_req[i]) exp_req.delete(i);
        exp_req = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h104,
                    32'h108, 32'h10C, 32'h100, 32'h104};
        exp_if  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104, 32'h108, 32'h100};

        step(); step();
        rst = 1'b0;
        step();
        check("first_req", {31'b0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h0);

        // Stall while pc 8 is presented and the word for 12 returns.
        wait_pc(32'h8);
        stall = 1'b1; lat = 1;
        step(); step(); step();
        check("hold_req_low", {31'b0, mem_req}, 32'd0);
        check("stall_pc", if_id_pc, 32'h8);
        check("stall_valid", {31'b0, if_id_valid}, 32'd1);
        stall = 1'b0;
        step();
        check("resume_req", {31'b0, mem_req}, 32'd1);
        check("resume_addr", mem_addr, 32'h10);

        // Redirect while the request for 16 is still outstanding.
        br = 1'b1; br_addr = 32'h100;
        step();
        br = 1'b0;
        check("br_addr_stable", mem_addr, 32'h10);
        check("br_bubble1", {31'b0, if_id_valid}, 32'd0);
        step();
        check("br_new_addr", mem_addr, 32'h100);
        check("br_bubble2", {31'b0, if_id_valid}, 32'd0);

        // Redirect together with stall is ignored.
        wait_pc(32'h100);
        stall = 1'b1; br = 1'b1; br_addr = 32'h200;
        step(); step();
        stall = 1'b0; br = 1'b0;

        // Unaligned redirect target is word-aligned.
        wait_pc(32'h108);
        br = 1'b1; br_addr = 32'h0000_0103;
        step();
        br = 1'b0;
        wait_pc(32'h100);
        stall = 1'b1;
        repeat (5) step();
        check("idle_req_low", {31'b0, mem_req}, 32'd0);
        check("req_q_drained", exp_req.size(), 32'd0);
        check("if_q_drained", exp_if.size(), 32'd0);

        // Asynchronous reset while a request is pending.
        lat = 3;
        step();
        exp_if.push_back(32'h104);
        stall = 1'b0;
        step();
        check("pre_rst_req", {31'b0, mem_req}, 32'd1);
        check("pre_rst_addr", mem_addr, 32'h108);
        step();
        #2 rst = 1'b1;
        #1;
        check("arst_mem_req", {31'b0, mem_req}, 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        check("arst_ifid_pc", if_id_pc, 32'd0);
        check("arst_ifid_inst", if_id_inst, BUBBLE);
        check("arst_ifid_valid", {31'b0, if_id_valid}, 32'd0);
        step(); step();
        lat = 0;
        exp_req = '{32'h0, 32'h4, 32'hFFFF_FFFC, 32'h0, 32'h4};
        exp_if  = '{32'h0, 32'hFFFF_FFFC, 32'h0};
        rst = 1'b0;
        step();
        check("rerst_req", {31'b0, mem_req}, 32'd1);
        check("rerst_addr", mem_addr, 32'h0);

        // Wrap from the top of the address space.
        wait_pc(32'h0);
        br = 1'b1; br_addr = 32'hFFFF_FFFC;
        step();
        br = 1'b0;
        wait_pc(32'hFFFF_FFFC);
        wait_pc(32'h0);
        stall = 1'b1;
        repeat (5) step();
        check("end_req_low", {31'b0, mem_req}, 32'd0);
        check("end_req_q", exp_req.size(), 32'd0);
        check("end_if_q", exp_if.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
